// File: rtl/io_display_out.sv
// io_display_out: memory-mapped LED / seven-segment output peripheral.
// Latches CPU IO writes into a 24-bit LED register, a 32-bit hex display
// value and an 8-bit digit-enable mask, and time-multiplexes the eight
// active-low seven-segment digits, one slot every SCAN_DIV clocks.
module io_display_out #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        LEDCtrl,
  input  logic        ioWrite,
  input  logic [3:0]  addr,
  input  logic [15:0] io_wdata,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  // Divider width; SCAN_DIV >= 2 keeps this at least one bit.
  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Active-low hex glyphs, decimal point always off (bit 7 high).
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Architectural registers written by the CPU.
  logic [23:0] led_q, led_d;
  logic [31:0] seg_val_q, seg_val_d;
  logic [7:0]  dig_en_q, dig_en_d;

  // Scan state and registered display drive.
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_an_q, seg_an_d;
  logic [7:0]       seg_out_q, seg_out_d;

  logic we;
  logic tick;

  // Per-digit glyph and anode pattern, precomputed so the scan mux is a
  // simple 8:1 select on idx.
  logic [7:0] digit_code [8];
  logic [7:0] digit_an   [8];

  assign we   = LEDCtrl & ioWrite;
  assign tick = (div_cnt_q == CNT_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign digit_code[gi] = hex7(seg_val_q[4*gi +: 4]);
      assign digit_an[gi]   = ~(8'h01 << gi);
    end
  endgenerate

  // Register-map decode: addr[3:1] selects the target, addr[0] is a don't-care.
  always_comb begin
    led_d     = led_q;
    seg_val_d = seg_val_q;
    dig_en_d  = dig_en_q;
    if (we) begin
      casez (addr)
        4'b000?: led_d[15:0]      = io_wdata;
        4'b001?: led_d[23:16]     = io_wdata[7:0];
        4'b010?: seg_val_d[15:0]  = io_wdata;
        4'b011?: seg_val_d[31:16] = io_wdata;
        4'b100?: dig_en_d         = io_wdata[7:0];
        default: ;
      endcase
    end
  end

  // Scan divider: free-running 0..SCAN_DIV-1, never disturbed by writes.
  always_comb begin
    div_cnt_d = tick ? '0 : (div_cnt_q + CNT_ONE);
  end

  // Digit scan: on each tick present the current slot (or blank it) using
  // the pre-write register contents, then advance to the next slot.
  always_comb begin
    seg_an_d  = seg_an_q;
    seg_out_d = seg_out_q;
    idx_d     = idx_q;
    if (tick) begin
      if (dig_en_q[idx_q]) begin
        seg_an_d  = digit_an[idx_q];
        seg_out_d = digit_code[idx_q];
      end else begin
        seg_an_d  = 8'hFF;
        seg_out_d = 8'hFF;
      end
      idx_d = idx_q + 3'd1;
    end
  end

  // CPU-visible registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      seg_val_q <= '0;
      dig_en_q  <= 8'hFF;
    end else begin
      led_q     <= led_d;
      seg_val_q <= seg_val_d;
      dig_en_q  <= dig_en_d;
    end
  end

  // Scan counters and registered display outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      seg_an_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg_an_q  <= seg_an_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign led     = led_q;
  assign seg_an  = seg_an_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_io_display_out.sv
// Testbench for io_display_out: a behavioural model predicts LED and
// display state each cycle into a queue; a negedge monitor pops and compares.
module tb_io_display_out;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        led_ctrl = 1'b0;
  logic        io_write = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  io_display_out #(.SCAN_DIV(SD)) dut (
    .clock   (clk),
    .reset   (rst_n),
    .LEDCtrl (led_ctrl),
    .ioWrite (io_write),
    .addr    (addr),
    .io_wdata(wdata),
    .led     (led),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ticks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] led;
    logic [7:0]  an;
    logic [7:0]  out;
    bit          tick;
  } exp_t;

  exp_t exp_q[$];

  int hex_tbl [16] = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'hF8,
                       'h80, 'h90, 'h88, 'h83, 'hC6, 'hA1, 'h86, 'h8E};

  logic [23:0] m_led;
  int          m_val [8];   // one hex nibble per digit
  bit          m_en  [8];
  logic [7:0]  m_an, m_out;
  int          cyc;         // rising edges since reset release
  int          m_d;
  exp_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = '0;
      for (int k = 0; k < 8; k++) begin
        m_val[k] = 0;
        m_en[k]  = 1'b1;
      end
      m_an  = 8'hFF;
      m_out = 8'hFF;
      cyc   = 0;
      exp_q.delete();
      m_e = '{led: m_led, an: m_an, out: m_out, tick: 1'b0};
      exp_q.push_back(m_e);
    end else begin
      cyc++;
      m_e.tick = 1'b0;
      if (cyc % SD == 0) begin
        // slot n (1-based) after release drives digit (n-1) mod 8
        m_d = (cyc / SD - 1) % 8;
        if (m_en[m_d]) begin
          m_an  = 8'hFF ^ (8'h01 << m_d);
          m_out = 8'(hex_tbl[m_val[m_d]]);
        end else begin
          m_an  = 8'hFF;
          m_out = 8'hFF;
        end
        m_e.tick = 1'b1;
      end
      if (led_ctrl && io_write) begin
        case (int'(addr) / 2)
          0: m_led = (m_led & 24'hFF0000) | 24'(wdata);
          1: m_led = (m_led & 24'h00FFFF) | (24'(wdata & 16'h00FF) << 16);
          2: for (int k = 0; k < 4; k++) m_val[k]     = (int'(wdata) >> (4 * k)) & 15;
          3: for (int k = 0; k < 4; k++) m_val[k + 4] = (int'(wdata) >> (4 * k)) & 15;
          4: for (int k = 0; k < 8; k++) m_en[k]      = ((int'(wdata) >> k) & 1) == 1;
          default: ;
        endcase
      end
      m_e.led = m_led;
      m_e.an  = m_an;
      m_e.out = m_out;
      exp_q.push_back(m_e);
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("led", 32'(led), 32'(mon_e.led));
      check("seg_an", 32'(seg_an), 32'(mon_e.an));
      check("seg_out", 32'(seg_out), 32'(mon_e.out));
      check("one_anode", 32'($countones(~seg_an) <= 1), 32'd1);
      if (mon_e.tick) n_ticks++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    led_ctrl = 1'b1;
    io_write = 1'b1;
    addr     = a;
    wdata    = d;
    step();
    led_ctrl = 1'b0;
    io_write = 1'b0;
  endtask

  // Advance until the model has just taken the tick that drives `digit`.
  task automatic align_after(input int digit);
    for (int i = 0; i < 16 * SD; i++) begin
      if (cyc % (8 * SD) == ((digit + 1) * SD) % (8 * SD)) break;
      step();
    end
    check("align", 32'(cyc % (8 * SD)), 32'(((digit + 1) * SD) % (8 * SD)));
  endtask

  logic [7:0] an_tbl  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] scan_out [8] = '{8'h92, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_led", 32'(led), 32'h0);
    check("rst_an", 32'(seg_an), 32'hFF);
    check("rst_out", 32'(seg_out), 32'hFF);
    rst_n = 1'b1;
    repeat (SD - 1) step();
    check("pre_first_tick_an", 32'(seg_an), 32'hFF);
    step();
    check("first_tick_an", 32'(seg_an), 32'hFE);
    check("first_tick_out", 32'(seg_out), 32'hC0);

    // LED writes
    wr(4'h0, 16'h1234);
    check("led_lo", 32'(led), 32'h001234);
    wr(4'h2, 16'hABCD);
    check("led_hi", 32'(led), 32'hCD1234);
    led_ctrl = 1'b1; io_write = 1'b0; addr = 4'h0; wdata = 16'hFFFF;
    step();
    check("led_no_iowrite", 32'(led), 32'hCD1234);
    led_ctrl = 1'b0; io_write = 1'b1;
    step();
    check("led_no_cs", 32'(led), 32'hCD1234);
    io_write = 1'b0;
    wr(4'hB, 16'h5555);   // unmapped slot
    check("led_unmapped", 32'(led), 32'hCD1234);

    // Hex scan
    wr(4'h4, 16'h00A5);
    wr(4'h6, 16'h0000);
    align_after(0);
    for (int k = 0; k < 8; k++) begin
      check("scan_an", 32'(seg_an), 32'(an_tbl[k]));
      check("scan_out", 32'(seg_out), 32'(scan_out[k]));
      repeat (SD) step();
    end

    // Blanking
    wr(4'h8, 16'h0001);
    align_after(0);
    for (int k = 0; k < 8; k++) begin
      check("blank_an", 32'(seg_an), (k == 0) ? 32'hFE : 32'hFF);
      check("blank_out", 32'(seg_out), (k == 0) ? 32'h92 : 32'hFF);
      repeat (SD) step();
    end

    // Write coinciding with the digit-0 tick
    wr(4'h8, 16'h00FF);
    for (int i = 0; i < 16 * SD; i++) begin
      if ((cyc + 1) % (8 * SD) == SD) break;
      step();
    end
    wr(4'h4, 16'h000F);
    check("collide_an", 32'(seg_an), 32'hFE);
    check("collide_old_out", 32'(seg_out), 32'h92);
    repeat (8 * SD) step();
    check("collide_next_an", 32'(seg_an), 32'hFE);
    check("collide_next_out", 32'(seg_out), 32'h8E);

    // Reset mid-frame while idx = 5
    align_after(4);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_an", 32'(seg_an), 32'hFF);
    check("midrst_out", 32'(seg_out), 32'hFF);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (SD - 1) step();
    check("midrst_wait_an", 32'(seg_an), 32'hFF);
    step();
    check("midrst_first_an", 32'(seg_an), 32'hFE);
    check("midrst_first_out", 32'(seg_out), 32'hC0);

    // Randomised traffic, including back-to-back writes
    for (int i = 0; i < 800; i++) begin
      led_ctrl = 1'($urandom_range(0, 1));
      io_write = 1'($urandom_range(0, 3) != 0);
      addr     = 4'($urandom_range(0, 11));
      wdata    = 16'($urandom);
      step();
    end
    led_ctrl = 1'b0;
    io_write = 1'b0;
    repeat (3) step();

    check("ticks_observed", 32'(n_ticks > 150), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_display_out.md
# io_display_out

Memory-mapped output peripheral directly downstream of the CPU's memory/IO address decoder. It consumes the LED chip-select, IO write strobe, low address bits and 16-bit IO write data, and latches them into a 24-bit LED register and a 32-bit seven-segment value register. It continuously time-multiplexes the eight seven-segment digits as hexadecimal, with per-digit blanking.

## Interface
- SCAN_DIV, default 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit); legal range ≥ 2.
- clock  in  1  system clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- LEDCtrl  in  1  chip select from the address decoder.
- ioWrite  in  1  IO write strobe from the controller.
- addr  in  4  low bits of the data address (addr_out[3:0]); bit 0 is ignored.
- io_wdata  in  16  IO write data.
- led  out  24  LED drive, active-high.
- seg_an  out  8  digit anodes, active-low; bit i drives digit i, digit 0 is rightmost.
- seg_out  out  8  segments, active-low; bit 7 is dp, bits 6..0 are g..a.

## Operation
- Write strobe: we = LEDCtrl & ioWrite. When we is low, io_wdata and addr are ignored.
- Register map, decoded on addr[3:1]:
  - 000: led[15:0] ← io_wdata
  - 001: led[23:16] ← io_wdata[7:0]
  - 010: seg_val[15:0] ← io_wdata
  - 011: seg_val[31:16] ← io_wdata
  - 100: dig_en[7:0] ← io_wdata[7:0]
  - 101–111: no effect
- Scan divider: div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt == SCAN_DIV-1).
- Scan index: idx is 3 bits.
- On each tick:
  - If dig_en[idx] = 1: seg_an ← ~(1<<idx) and seg_out ← hex(seg_val[4*idx+3 : 4*idx]).
  - Else: seg_an ← 8'hFF and seg_out ← 8'hFF.
  - Then idx ← idx+1, wrapping 7→0.
- Hex encoding (active-low, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.
- dp is always off (seg_out[7] = 1).

## Timing
- Reset (asynchronous, while reset = 0): led = 0, seg_val = 0, dig_en = 8'hFF, div_cnt = 0, idx = 0, seg_an = 8'hFF, seg_out = 8'hFF. Takes effect immediately, mid-scan included.
- Write latency: a register written at rising edge N shows its new value on led at edge N, with no combinational path from io_wdata to any output.
- First display: the first tick after reset release occurs on the SCAN_DIV-th rising edge. That tick drives digit 0.
- Digit dwell: each digit is driven for exactly SCAN_DIV cycles. A full frame is 8*SCAN_DIV cycles.
- Outputs seg_an and seg_out are registered and change only on tick edges.
- Write coinciding with a tick: the tick samples the pre-write seg_val and dig_en. The new value appears at the next tick that visits that digit.
- Writes never reset div_cnt or idx.
- Back-to-back writes on consecutive cycles are all accepted. When two writes hit the same address, the last one wins.
- At most one digit anode is low at any time.

## Test plan
- Reset check (SCAN_DIV=4): hold reset low → led=0, seg_an=FF, seg_out=FF. Release reset, then 4 edges later → seg_an=FE, seg_out=C0.
- LED writes: we=1, addr=0, io_wdata=1234 → led=001234 after the edge. Then addr=2, io_wdata=ABCD → led=CD1234. Then ioWrite=0, addr=0, io_wdata=FFFF → led unchanged.
- Hex scan: write seg_val lo=00A5 and hi=0000. The next eight ticks give:
  - seg_an FE with seg_out 92
  - seg_an FD with seg_out 88
  - seg_an FB/F7/EF/DF/BF/7F, each with seg_out C0
- Blanking: write dig_en=01 → digit 0 shows its code with seg_an=FE. The seven other slots show seg_an=FF and seg_out=FF.
- Write/tick collision: write seg_val lo=000F on the same edge that tick drives digit 0 → that slot still shows the old code. Digit 0 shows 8E from the next frame onward.
- Reset mid-frame: assert reset while idx=5 → all outputs return to reset values immediately. After release, the first tick drives digit 0 after SCAN_DIV cycles.
